// File: rtl/sdp_fifo_pkg.sv
// Shared defaults and types for the sdp_fifo_ctrl deep buffer.
// Storage geometry matches the ram_sdp 1024x32 macro.
package sdp_fifo_pkg;

  localparam int unsigned SDP_ADDR_W  = 10;
  localparam int unsigned SDP_DATA_W  = 32;
  localparam int unsigned SDP_DEPTH   = 2**SDP_ADDR_W;
  localparam int unsigned SDP_LEVEL_W = SDP_ADDR_W + 1;

  typedef logic [SDP_LEVEL_W-1:0] sdp_level_t;

  // Per-cycle handshake events derived from both sides of the buffer.
  typedef struct packed {
    logic push;
    logic pop;
    logic issue;
  } sdp_evt_t;

endpackage

// File: rtl/sdp_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sdp_fifo_ctrl.
// SDP_FIFO_PEAK_EN adds the clr_peak / peak_level pair.
interface sdp_fifo_ctrl_if
  import sdp_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = SDP_ADDR_W,
  parameter int unsigned DATA_W = SDP_DATA_W
);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   level;
`ifdef SDP_FIFO_PEAK_EN
  logic              clr_peak;
  logic [ADDR_W:0]   peak_level;
`endif

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
`ifdef SDP_FIFO_PEAK_EN
    , output clr_peak
    , input  peak_level
`endif
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
`ifdef SDP_FIFO_PEAK_EN
    , input  clr_peak
    , output peak_level
`endif
  );

endinterface

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: write port A, registered read port B (1-cycle latency).
// Read of an address being written in the same cycle returns the old contents.
module ram_sdp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dob
);

  logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

  // Write port A and registered read port B; dob holds while enb is low.
  always_ff @(posedge clk) begin
    if (ena && wea) begin
      mem_r[addra] <= dia;
    end
    if (enb) begin
      dob <= mem_r[addrb];
    end
  end

endmodule

// File: rtl/sdp_fifo_ctrl.sv
// First-word-fall-through FIFO controller over ram_sdp; the RAM output register is the head.
// Define SDP_FIFO_PEAK_EN to add the clr_peak / peak_level high-water tracker.
module sdp_fifo_ctrl
  import sdp_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = SDP_ADDR_W,
  parameter int unsigned DATA_W = SDP_DATA_W
) (
  input logic            clk,
  input logic            rst_n,
  sdp_fifo_ctrl_if.slave bus
);

  localparam int unsigned       DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   mem_count_r;
  logic [ADDR_W:0]   level_r;
  logic              out_valid_r;

  logic              in_ready_s;
  sdp_evt_t          evt_s;
  logic [ADDR_W:0]   mem_count_nxt_s;
  logic [ADDR_W:0]   level_nxt_s;
  logic              out_valid_nxt_s;
  logic [DATA_W-1:0] ram_dob_s;

  // Handshake decode; flush blocks both the write side and new read issues.
  always_comb begin
    in_ready_s  = 1'b0;
    evt_s.issue = 1'b0;
    if (bus.flush) begin
      in_ready_s  = 1'b0;
      evt_s.issue = 1'b0;
    end else begin
      in_ready_s  = (mem_count_r < DEPTH_CNT);
      evt_s.issue = (mem_count_r != CNT_ZERO) && (!out_valid_r || bus.out_ready);
    end
    evt_s.push = bus.in_valid && in_ready_s;
    evt_s.pop  = out_valid_r && bus.out_ready;
  end

  // Next-state occupancy; a word only counts in mem_count after its write edge.
  always_comb begin
    mem_count_nxt_s = mem_count_r;
    out_valid_nxt_s = out_valid_r;
    if (bus.flush) begin
      mem_count_nxt_s = CNT_ZERO;
      out_valid_nxt_s = 1'b0;
    end else begin
      mem_count_nxt_s = mem_count_r
                      + {{ADDR_W{1'b0}}, evt_s.push}
                      - {{ADDR_W{1'b0}}, evt_s.issue};
      if (evt_s.issue) begin
        out_valid_nxt_s = 1'b1;
      end else if (evt_s.pop) begin
        out_valid_nxt_s = 1'b0;
      end else begin
        out_valid_nxt_s = out_valid_r;
      end
    end
    level_nxt_s = mem_count_nxt_s + {{ADDR_W{1'b0}}, out_valid_nxt_s};
  end

  // Pointer, count, head-valid and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      mem_count_r <= CNT_ZERO;
      out_valid_r <= 1'b0;
      level_r     <= CNT_ZERO;
    end else begin
      if (bus.flush) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
      end else begin
        if (evt_s.push) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (evt_s.issue) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      mem_count_r <= mem_count_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      level_r     <= level_nxt_s;
    end
  end

`ifdef SDP_FIFO_PEAK_EN
  logic [ADDR_W:0] peak_level_r;

  // High-water mark of level; clr_peak restarts tracking from the next level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_level_r <= CNT_ZERO;
    end else if (bus.flush) begin
      peak_level_r <= CNT_ZERO;
    end else if (bus.clr_peak) begin
      peak_level_r <= level_nxt_s;
    end else if (level_nxt_s > peak_level_r) begin
      peak_level_r <= level_nxt_s;
    end else begin
      peak_level_r <= peak_level_r;
    end
  end

  assign bus.peak_level = peak_level_r;
`endif

  ram_sdp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .ena   (evt_s.push),
    .wea   (evt_s.push),
    .addra (wr_ptr_r),
    .dia   (bus.in_data),
    .enb   (evt_s.issue),
    .addrb (rd_ptr_r),
    .dob   (ram_dob_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_valid_r ? ram_dob_s : {DATA_W{1'b0}};
  assign bus.level     = level_r;

endmodule
